// File: rtl/pong_pkg.sv
// pong_pkg: shared encodings and constants for the Pong game controller.
//   game_state_t  : 2-bit game state encoding (also driven out on game_state)
//   BCD_MAX_DIGIT : largest legal BCD digit value
//   SPEED_MAX     : saturation value of the ball speed level
//   bcd_next()    : single BCD digit increment with 9 -> 0 wrap
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } game_state_t;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [1:0] SPEED_MAX     = 2'd3;

    function automatic logic [3:0] bcd_next(input logic [3:0] d);
        return (d == BCD_MAX_DIGIT) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/pong_bcd_score.sv
// pong_bcd_score: two-digit BCD score counter, 00..99 with wrap to 00.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-low reset (clears to 00)
//   clr       in   synchronous clear to 00 (has priority over inc)
//   inc       in   add one to the score on this edge
//   tens      out  BCD tens digit
//   ones      out  BCD ones digit
//   wrap_ones out  high in the cycle whose edge wraps ones 9 -> 0
module pong_bcd_score
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap_ones
);

    // Combinational so a consumer can act on the same edge the wrap happens.
    assign wrap_ones = reset && inc && !clr && (ones == BCD_MAX_DIGIT);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            ones <= bcd_next(ones);
            if (ones == BCD_MAX_DIGIT)
                tens <= bcd_next(tens);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: top-level game sequencer for the Pong VGA design.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-low reset
//   btn_any      in   OR of debounced paddle buttons (level)
//   hit          in   pulse: ball struck a paddle
//   miss         in   pulse: ball passed a paddle
//   timer_up     in   external delay timer has reached zero (level)
//   timer_start  out  reload pulse to the delay timer (combinational)
//   graph_still  out  1 = freeze ball, show static graphics
//   game_state   out  current state encoding
//   balls_left   out  balls remaining after the one in play
//   score_tens   out  BCD tens digit
//   score_ones   out  BCD ones digit
//   speed_lvl    out  ball speed level
// Build option: PONG_SPEEDUP_EN enables the speed_lvl register; otherwise
// speed_lvl is tied to 0.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_NEWGAME | idle, score 00, full ball stock, wait for a button
// ST_PLAY    | ball in play, hits score, a miss loses the ball
// ST_NEWBALL | ball lost, wait for timer_up and a button to respawn
// ST_OVER    | no balls left, wait for timer_up then back to NEWGAME
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_BALLS = 3,
    parameter int BW        = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_any,
    input  logic          hit,
    input  logic          miss,
    input  logic          timer_up,
    output logic          timer_start,
    output logic          graph_still,
    output logic [1:0]    game_state,
    output logic [BW-1:0] balls_left,
    output logic [3:0]    score_tens,
    output logic [3:0]    score_ones,
    output logic [1:0]    speed_lvl
);

    localparam logic [BW-1:0] BALLS_INIT = BW'(NUM_BALLS);

    game_state_t state, state_nxt;
    logic        ball_dec;
    logic        new_game_clr;
    logic        score_inc;
    logic        wrap_ones;

    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_NEWGAME;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ball_dec     = 1'b0;
        new_game_clr = 1'b0;
        score_inc    = 1'b0;
        timer_start  = 1'b0;
        case (state)
            ST_NEWGAME: begin
                if (btn_any) begin
                    state_nxt = ST_PLAY;
                    ball_dec  = 1'b1;
                end
            end
            ST_PLAY: begin
                // A miss in the same cycle as a hit discards the hit.
                if (miss) begin
                    timer_start = 1'b1;
                    state_nxt   = (balls_left == '0) ? ST_OVER : ST_NEWBALL;
                end else if (hit) begin
                    score_inc = 1'b1;
                end
            end
            ST_NEWBALL: begin
                if (timer_up && btn_any) begin
                    state_nxt = ST_PLAY;
                    ball_dec  = 1'b1;
                end
            end
            ST_OVER: begin
                if (timer_up) begin
                    state_nxt    = ST_NEWGAME;
                    new_game_clr = 1'b1;
                end
            end
            default: state_nxt = ST_NEWGAME;
        endcase
    end

    // Decrement only on entry to PLAY; OVER is taken at zero so no underflow.
    always_ff @(posedge clk) begin
        if (!reset || new_game_clr)
            balls_left <= BALLS_INIT;
        else if (ball_dec)
            balls_left <= balls_left - BW'(1);
    end

    pong_bcd_score u_score (
        .clk       (clk),
        .reset     (reset),
        .clr       (new_game_clr),
        .inc       (score_inc),
        .tens      (score_tens),
        .ones      (score_ones),
        .wrap_ones (wrap_ones)
    );

`ifdef PONG_SPEEDUP_EN
    logic [1:0] speed_q;

    always_ff @(posedge clk) begin
        if (!reset || new_game_clr)
            speed_q <= 2'd0;
        else if (wrap_ones && (speed_q != SPEED_MAX))
            speed_q <= speed_q + 2'd1;
    end

    assign speed_lvl = speed_q;
`else
    logic unused_wrap_ones;
    assign unused_wrap_ones = wrap_ones;
    assign speed_lvl        = 2'b00;
`endif

    assign graph_still = (state != ST_PLAY);
    assign game_state  = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: directed game walk-through followed by
// randomized play, checked against a score/ball-count game model.
module tb_pong_game_ctrl;

    localparam int NB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_any = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       timer_up = 1'b0;
    logic       timer_start;
    logic       graph_still;
    logic [1:0] game_state;
    logic [2:0] balls_left;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [1:0] speed_lvl;

    pong_game_ctrl #(.NUM_BALLS(NB), .BW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_any     (btn_any),
        .hit         (hit),
        .miss        (miss),
        .timer_up    (timer_up),
        .timer_start (timer_start),
        .graph_still (graph_still),
        .game_state  (game_state),
        .balls_left  (balls_left),
        .score_tens  (score_tens),
        .score_ones  (score_ones),
        .speed_lvl   (speed_lvl)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit      chk_ts;
        bit      ts;
        int      st;
        int      balls;
        int      score;
        int      spd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Game model: phase names 0 newgame, 1 play, 2 newball, 3 over.
    bit known = 0;
    int m_st = 0;
    int m_balls = NB;
    int m_score = 0;
    int m_spd = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit b, input bit h, input bit m, input bit t);
        exp_t e;
        @(negedge clk);
        reset = r; btn_any = b; hit = h; miss = m; timer_up = t;
        e.chk_ts = known;
        e.ts = known && (m_st == 1) && m;
        if (!r) begin
            known = 1; m_st = 0; m_balls = NB; m_score = 0; m_spd = 0;
        end else if (known) begin
            case (m_st)
                0: if (b) begin m_st = 1; m_balls--; end
                1: begin
                    if (m) m_st = (m_balls == 0) ? 3 : 2;
                    else if (h) begin
`ifdef PONG_SPEEDUP_EN
                        if (m_score % 10 == 9 && m_spd < 3) m_spd++;
`endif
                        m_score = (m_score + 1) % 100;
                    end
                end
                2: if (t && b) begin m_st = 1; m_balls--; end
                default: if (t) begin m_st = 0; m_balls = NB; m_score = 0; m_spd = 0; end
            endcase
        end
        e.st = m_st; e.balls = m_balls; e.score = m_score; e.spd = m_spd;
        q.push_back(e);
    endtask

    // Monitor: timer_start is checked against the inputs of the cycle, the
    // registered outputs just after the following edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.chk_ts) check("timer_start", int'(timer_start), int'(e.ts));
                @(posedge clk);
                #1;
                check("game_state", int'(game_state), e.st);
                check("graph_still", int'(graph_still), (e.st != 1) ? 1 : 0);
                check("balls_left", int'(balls_left), e.balls);
                check("score_tens", int'(score_tens), e.score / 10);
                check("score_ones", int'(score_ones), e.score % 10);
                check("speed_lvl", int'(speed_lvl), e.spd);
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);                                   // start: PLAY, 2 left
        for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0);      // score 12
        for (int i = 0; i < 88; i++) step(1, 0, 1, 0, 0);      // 99 -> 00
        step(1, 0, 1, 1, 0);                                   // miss beats hit
        for (int i = 0; i < 50; i++) step(1, 1, 0, 0, 0);      // no timer, stay
        step(1, 0, 1, 1, 1);                                   // timer without button
        step(1, 1, 0, 0, 1);                                   // PLAY, 1 left
        step(1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1);                                   // PLAY, 0 left
        for (int i = 0; i < 35; i++) step(1, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0);                                   // OVER
        for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0);       // ignored in OVER
        step(1, 1, 0, 0, 1);                                   // NEWGAME
        step(1, 1, 0, 0, 0);                                   // held button starts game
        step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);                                   // reset mid-PLAY
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for the Pong VGA design.
- Owns the game state machine: new game, ball in play, ball respawn delay, game over.
- Tracks balls remaining and a 2-digit BCD score.
- Drives the shared 7-bit countdown delay timer through timer_start and consumes its timer_up.
- Gates the pixel/graph logic via graph_still.
- Feeds state and score to the text overlay.

Parameters:
NUM_BALLS, 3, balls per game; legal range 1..7.
BW, 3, width of balls_left; must hold NUM_BALLS.

Ports:
clk  input  1  system clock (100 MHz).
reset  input  1  synchronous, active-low reset.
btn_any  input  1  OR of debounced paddle buttons, level.
hit  input  1  one-cycle pulse: ball struck a paddle.
miss  input  1  one-cycle pulse: ball passed a paddle.
timer_up  input  1  delay timer at zero, level.
timer_start  output  1  reload pulse to the delay timer.
graph_still  output  1  1 = freeze ball, show static graphics.
game_state  output  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
balls_left  output  BW  balls remaining after the one in play.
score_tens  output  4  BCD tens digit.
score_ones  output  4  BCD ones digit.
speed_lvl  output  2  ball speed level; see Optional Feature.

Behaviour:
- One clock. Reset is synchronous and active-low: sampled only on the rising edge of clk while reset==0.
- Reset values:
  - state NEWGAME, balls_left=NUM_BALLS, score 00, speed_lvl 0.
  - graph_still=1, timer_start=0.
  - Reset asserted mid-game aborts immediately to these values.
- All state, counter and score registers update on the rising edge of clk.
- timer_start is combinational: 1 only when state==PLAY && miss. The timer reloads on the same edge that leaves PLAY, so timer_up reads 0 on entry to NEWBALL or OVER.
- graph_still = (state != PLAY). game_state is the state register.
- State transitions:
  - NEWGAME: score held at 00, balls_left held at NUM_BALLS. btn_any=1 -> PLAY, balls_left decrements by 1 on the same edge.
  - PLAY, hit only: score increments in BCD. Ones 9->0 carries into tens. 99 wraps to 00. State stays PLAY.
  - PLAY, miss with balls_left==0: -> OVER.
  - PLAY, miss with balls_left!=0: -> NEWBALL.
  - PLAY, hit and miss in the same cycle: miss wins and the hit is discarded (no score change).
  - NEWBALL: hit/miss ignored. timer_up && btn_any -> PLAY, balls_left decrements by 1. btn_any alone never exits.
  - OVER: all inputs except timer_up ignored. timer_up -> NEWGAME. Score stays visible until NEWGAME entry.
  - NEWGAME clears score, balls_left and speed_lvl on the edge that enters it.
- hit/miss outside PLAY: ignored.
- Holding btn_any through OVER into NEWGAME starts a new game on the first NEWGAME cycle. This is intended.
- balls_left never underflows. Decrement happens only on entering PLAY, and OVER is taken when a ball is lost with balls_left==0.

Optional Feature:
Macro: PONG_SPEEDUP_EN.
- Defined: speed_lvl increments on each hit that wraps score_ones 9->0, saturating at 3. It is cleared on NEWGAME entry and on reset. The ball module uses it to scale its velocity.
- Undefined: speed_lvl is tied to 2'b00 and no register is inferred. The port list is identical in both builds.

Decomposition:
- Shared package pong_pkg:
  - state encodings ST_NEWGAME/ST_PLAY/ST_NEWBALL/ST_OVER (2 bits).
  - BCD_MAX_DIGIT = 4'd9.
  - SPEED_MAX = 2'd3.
- One natural sub-module: pong_bcd_score (2-digit BCD counter).
  - Inputs: clr, inc.
  - Outputs: tens, ones, and wrap_ones (1-cycle pulse when ones wraps).
  - The controller instantiates it and uses wrap_ones for speed_lvl.
- The countdown timer stays external; the controller only drives timer_start.

Test Plan:
1. Reset low for 2 cycles, then btn_any=1 -> game_state 01, balls_left 2, graph_still 0, score 00.
2. In PLAY, 12 hit pulses -> score_tens 1, score_ones 2. Continue to 99 plus 1 more hit -> 00.
3. hit and miss in the same cycle with balls_left 2 -> timer_start=1 for exactly that cycle, score unchanged, next state NEWBALL, balls_left stays 2.
4. NEWBALL with btn_any=1 and timer_up=0 for 50 cycles -> stays NEWBALL. Raise timer_up -> PLAY, balls_left 1.
5. Lose all 3 balls -> OVER on the 3rd miss. timer_up -> NEWGAME, score 00, balls_left 3. Reset pulled low mid-PLAY -> NEWGAME next edge.
6. With PONG_SPEEDUP_EN: 35 hits -> speed_lvl 3. 10 more -> still 3. Without the macro -> speed_lvl 0 throughout.
